// File: rtl/PKG_pwm.sv
// rtl/PKG_pwm.sv - shared PWM types, config-word field positions and counter width
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package PKG_pwm;

  localparam int PWMCOUNT_WIDTH = `PWMCOUNT_WIDTH;

  localparam int CFG_COUNTMODE_LSB = 0;
  localparam int CFG_MASK_BIT      = 2;
  localparam int CFG_INT_BIT       = 3;
  localparam int CFG_ONOFF_BIT     = 4;
  localparam int CFG_USED_BITS     = 5;

  typedef enum logic [1:0] {
    CNT_UP     = 2'b00,
    CNT_DOWN   = 2'b01,
    CNT_UPDOWN = 2'b10,
    CNT_RSVD   = 2'b11
  } _count_mode;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN_UP   = 2'b01,
    ST_RUN_DOWN = 2'b10
  } _cnt_state;

endpackage

// File: rtl/pwm_cfg_unpack.sv
// rtl/pwm_cfg_unpack.sv - combinational split of the packed PWM config word into its fields
module pwm_cfg_unpack
  import PKG_pwm::*;
(
  input  logic [PWMCOUNT_WIDTH-1:0] config_reg,
  output logic [1:0]                count_mode,
  output logic                      mask_mode,
  output logic                      int_onoff,
  output logic                      pwm_onoff
);

  logic unused_upper;

  assign count_mode = config_reg[CFG_COUNTMODE_LSB +: 2];
  assign mask_mode  = config_reg[CFG_MASK_BIT];
  assign int_onoff  = config_reg[CFG_INT_BIT];
  assign pwm_onoff  = config_reg[CFG_ONOFF_BIT];

  assign unused_upper = ^config_reg[PWMCOUNT_WIDTH-1:CFG_USED_BITS];

endmodule

// File: rtl/pwm_carrier_counter.sv
// rtl/pwm_carrier_counter.sv - PWM carrier counter (up/down/up-down) with compare, events and irq.
// Define PWMCNT_SHADOW_EN to make period/compare shadow registers loaded in IDLE and at zero events.
module pwm_carrier_counter
  import PKG_pwm::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PWMCOUNT_WIDTH-1:0] config_reg,
  input  logic [PWMCOUNT_WIDTH-1:0] period,
  input  logic [PWMCOUNT_WIDTH-1:0] compare,
  output logic [PWMCOUNT_WIDTH-1:0] count,
  output logic                      dir_down,
  output logic                      pwm_raw,
  output logic                      zero_evt,
  output logic                      period_evt,
  output logic                      irq
);

  localparam logic [PWMCOUNT_WIDTH-1:0] CNT_ONE = {{(PWMCOUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0] cfg_mode_raw;
  logic       mask_mode;
  logic       int_onoff;
  logic       pwm_onoff;

  pwm_cfg_unpack u_cfg_unpack (
    .config_reg (config_reg),
    .count_mode (cfg_mode_raw),
    .mask_mode  (mask_mode),
    .int_onoff  (int_onoff),
    .pwm_onoff  (pwm_onoff)
  );

  _count_mode                cfg_mode;
  _count_mode                eff_mode;
  _count_mode                mode_q, mode_d;
  _cnt_state                 state_q, state_d;
  logic [PWMCOUNT_WIDTH-1:0] count_q, count_d;
  logic [PWMCOUNT_WIDTH-1:0] period_act, compare_act, period_use;
  logic                      irq_q, irq_d;
  logic                      running;

  assign cfg_mode = _count_mode'(cfg_mode_raw);

`ifdef PWMCNT_SHADOW_EN
  logic [PWMCOUNT_WIDTH-1:0] period_sh_q, compare_sh_q;
  logic                      shadow_load;

  assign shadow_load = (state_q == ST_IDLE) || zero_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_sh_q  <= '0;
      compare_sh_q <= '0;
    end else if (shadow_load) begin
      period_sh_q  <= period;
      compare_sh_q <= compare;
    end
  end

  assign period_act  = period_sh_q;
  assign compare_act = compare_sh_q;
  // On a load edge the next count must already obey the incoming period.
  assign period_use  = shadow_load ? period : period_sh_q;
`else
  assign period_act  = period;
  assign compare_act = compare;
  assign period_use  = period;
`endif

  assign running    = (state_q != ST_IDLE);
  assign count      = count_q;
  assign dir_down   = (state_q == ST_RUN_DOWN);
  assign zero_evt   = running && (count_q == '0);
  assign period_evt = running && (count_q == period_act);
  assign pwm_raw    = running && (count_q < compare_act);
  assign irq        = irq_q;

  // A new count_mode only takes over at a zero event; otherwise the latched mode runs.
  assign eff_mode = zero_evt ? cfg_mode : mode_q;

  assign irq_d = int_onoff && (zero_evt || (!mask_mode && period_evt));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    if (state_q == ST_IDLE) begin
      mode_d  = cfg_mode;
      count_d = '0;
      if (pwm_onoff && (cfg_mode != CNT_RSVD)) begin
        if (cfg_mode == CNT_DOWN) begin
          state_d = ST_RUN_DOWN;
          count_d = period;
        end else begin
          state_d = ST_RUN_UP;
        end
      end
    end else if (!pwm_onoff || (eff_mode == CNT_RSVD)) begin
      state_d = ST_IDLE;
      count_d = '0;
      mode_d  = eff_mode;
    end else begin
      mode_d = eff_mode;
      case (eff_mode)
        CNT_UP: begin
          state_d = ST_RUN_UP;
          count_d = (count_q >= period_use) ? '0 : count_q + CNT_ONE;
        end
        CNT_DOWN: begin
          state_d = ST_RUN_DOWN;
          count_d = ((count_q == '0) || (count_q > period_use)) ? period_use : count_q - CNT_ONE;
        end
        default: begin
          // Direction flips on arrival at an endpoint so each endpoint shows for one cycle.
          if (period_use == '0) begin
            state_d = ST_RUN_UP;
            count_d = '0;
          end else if ((state_q == ST_RUN_DOWN) && (count_q > period_use)) begin
            state_d = ST_RUN_DOWN;
            count_d = period_use;
          end else if ((state_q == ST_RUN_DOWN) && (count_q != '0)) begin
            count_d = count_q - CNT_ONE;
            state_d = (count_q == CNT_ONE) ? ST_RUN_UP : ST_RUN_DOWN;
          end else if (count_q >= period_use) begin
            count_d = period_use - CNT_ONE;
            state_d = (period_use == CNT_ONE) ? ST_RUN_UP : ST_RUN_DOWN;
          end else begin
            count_d = count_q + CNT_ONE;
            state_d = ((count_q + CNT_ONE) == period_use) ? ST_RUN_DOWN : ST_RUN_UP;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= CNT_UP;
      count_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_pwm_carrier_counter.sv
// tb/tb_pwm_carrier_counter.sv - self-checking bench for pwm_carrier_counter
module tb_pwm_carrier_counter;
  import PKG_pwm::*;

  localparam int W = PWMCOUNT_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] config_reg = '0;
  logic [W-1:0] period = '0;
  logic [W-1:0] compare = '0;
  logic [W-1:0] count;
  logic         dir_down, pwm_raw, zero_evt, period_evt, irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_carrier_counter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .config_reg (config_reg),
    .period     (period),
    .compare    (compare),
    .count      (count),
    .dir_down   (dir_down),
    .pwm_raw    (pwm_raw),
    .zero_evt   (zero_evt),
    .period_evt (period_evt),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Closed-form carrier position k cycles after leaving IDLE with a fixed config.
  function automatic int ref_cnt(input int m, input int p, input int k);
    int t;
    if (m == 0) return k % (p + 1);
    if (m == 1) return p - (k % (p + 1));
    if (p == 0) return 0;
    t = k % (2 * p);
    return (t <= p) ? t : 2 * p - t;
  endfunction

  function automatic int ref_dir(input int m, input int p, input int k);
    if (m == 1) return 1;
    if (m == 0 || p == 0) return 0;
    return ((k % (2 * p)) >= p) ? 1 : 0;
  endfunction

  task automatic set_cfg(input int on, input int m, input int mask, input int intr);
    logic [W-1:0] v;
    v = '0;
    v[W-1:CFG_USED_BITS] = (W-CFG_USED_BITS)'($urandom);
    v[1:0] = m[1:0];
    v[CFG_MASK_BIT] = mask[0];
    v[CFG_INT_BIT] = intr[0];
    v[CFG_ONOFF_BIT] = on[0];
    config_reg = v;
  endtask

  task automatic chk_idle(input string tag, input int exp_irq);
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".dir_down"}, 32'(dir_down), 0);
    chk({tag, ".pwm_raw"}, 32'(pwm_raw), 0);
    chk({tag, ".zero_evt"}, 32'(zero_evt), 0);
    chk({tag, ".period_evt"}, 32'(period_evt), 0);
    chk({tag, ".irq"}, 32'(irq), exp_irq);
  endtask

  // Starts from IDLE at a negedge, runs ncyc checked cycles, switches off and checks IDLE.
  task automatic run_seg(input int m, input int p, input int c, input int mask, input int intr, input int ncyc);
    int cnt, exp_irq;
    period = W'(p);
    compare = W'(c);
    set_cfg(1, m, mask, intr);
    exp_irq = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      cnt = ref_cnt(m, p, k);
      chk("seg.count", 32'(count), cnt);
      chk("seg.dir_down", 32'(dir_down), ref_dir(m, p, k));
      chk("seg.pwm_raw", 32'(pwm_raw), (cnt < c) ? 1 : 0);
      chk("seg.zero_evt", 32'(zero_evt), (cnt == 0) ? 1 : 0);
      chk("seg.period_evt", 32'(period_evt), (cnt == p) ? 1 : 0);
      chk("seg.irq", 32'(irq), exp_irq);
      exp_irq = (intr != 0 && (cnt == 0 || (mask == 0 && cnt == p))) ? 1 : 0;
    end
    set_cfg(0, m, mask, intr);
    @(negedge clk);
    chk_idle("seg_off", exp_irq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_q[$];
    int dir_q[$];

    set_cfg(1, 0, 0, 1);
    period = 16'd4;
    repeat (2) @(negedge clk);
    chk_idle("reset", 0);
    rst_n = 1'b1;
    set_cfg(0, 0, 0, 0);
    @(negedge clk);
    chk_idle("idle_after_reset", 0);

    run_seg(0, 4, 2, 0, 1, 12);
    run_seg(2, 3, 2, 0, 0, 14);
    run_seg(1, 5, 3, 1, 1, 20);
    run_seg(0, 9, 4, 0, 0, 7);
    run_seg(1, 7, 3, 0, 1, 10);
    run_seg(0, 0, 1, 0, 1, 4);
    run_seg(2, 0, 0, 0, 1, 4);
    run_seg(2, 1, 1, 0, 1, 6);

    // Reserved mode keeps the counter stopped.
    period = 16'd5;
    set_cfg(1, 3, 0, 1);
    repeat (3) begin
      @(negedge clk);
      chk_idle("mode11", 0);
    end
    set_cfg(0, 0, 0, 0);
    @(negedge clk);

    // Mode change mid-period takes effect at the next zero event.
    period = 16'd4;
    compare = 16'd2;
    set_cfg(1, 0, 0, 0);
    exp_q = '{0, 1, 2, 3, 4, 0, 4, 3, 2, 1, 0, 4};
    dir_q = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("modechg.count", 32'(count), exp_q[k]);
      chk("modechg.dir_down", 32'(dir_down), dir_q[k]);
      if (k == 2) set_cfg(1, 1, 0, 0);
    end
    set_cfg(0, 0, 0, 0);
    @(negedge clk);
    chk_idle("modechg_off", 0);

    // Period shrunk mid-run at count 5.
    period = 16'd9;
    compare = 16'd5;
    set_cfg(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("shrink.pre", 32'(count), k);
    end
    period = 16'd3;
`ifdef PWMCNT_SHADOW_EN
    exp_q = '{6, 7, 8, 9, 0, 1, 2, 3, 0};
`else
    exp_q = '{0, 1, 2, 3, 0, 1};
`endif
    foreach (exp_q[i]) begin
      @(negedge clk);
      chk("shrink.count", 32'(count), exp_q[i]);
    end
    set_cfg(0, 0, 0, 0);
    @(negedge clk);
    chk_idle("shrink_off", 0);

    // Asynchronous reset mid-run at count 2, then restart.
    period = 16'd9;
    compare = 16'd4;
    set_cfg(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("prerst.count", 32'(count), k);
    end
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst", 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("postrst.count", 32'(count), k);
      chk("postrst.zero_evt", 32'(zero_evt), (k == 0) ? 1 : 0);
    end
    set_cfg(0, 0, 0, 0);
    @(negedge clk);
    chk_idle("postrst_off", 0);

    for (int i = 0; i < 12; i++) begin
      run_seg(int'($urandom_range(0, 2)), int'($urandom_range(0, 12)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(5, 40)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
